instr_decode: RTL and testbench

Instruction-decode stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch. It consumes the IF/ID instruction and PC, reads the 32×32 register file, generates immediates and control, and detects load-use hazards. It drives the hold line back to fetch and registers everything into the ID/EX pipeline register. The register-file write port is driven from write-back.

---
 rtl/instr_decode.sv | 221 ++++++++++++++++++++++
 tb/tb_instr_decode.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// instr_decode: RV32I instruction-decode stage with ID/EX pipeline register.
//
// Reads the 32x32 register file, generates immediates and control signals,
// detects load-use hazards and registers the decoded result into ID/EX.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   instruction_in, PC_in IF/ID instruction and PC (instruction 0 = bubble)
//   PCSrc                 downstream taken branch/jump; flushes this stage
//   RegWrite_wb, rd_wb,   write-back port into the register file
//   wdata_wb
//   stall_out             combinational hold request to fetch (PCWrite)
//   *_out                 ID/EX pipeline register contents
//
// Build option: define RF_WB_BYPASS_EN to forward same-cycle write-back data
// onto the register-file read ports; otherwise such a read sees the old value.
module instr_decode #(
   parameter int unsigned RF_DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction_in,
   input  logic [31:0] PC_in,
   input  logic        PCSrc,
   input  logic        RegWrite_wb,
   input  logic [4:0]  rd_wb,
   input  logic [31:0] wdata_wb,
   output logic        stall_out,
   output logic [31:0] PC_out,
   output logic [31:0] rdata1_out,
   output logic [31:0] rdata2_out,
   output logic [31:0] imm_out,
   output logic [4:0]  rs1_out,
   output logic [4:0]  rs2_out,
   output logic [4:0]  rd_out,
   output logic [2:0]  funct3_out,
   output logic        funct7b5_out,
   output logic [1:0]  ALUOp_out,
   output logic [1:0]  ASrc_out,
   output logic        ALUSrc_out,
   output logic        MemRead_out,
   output logic        MemWrite_out,
   output logic        MemtoReg_out,
   output logic        RegWrite_out,
   output logic        Branch_out,
   output logic        Jump_out
);

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpIAlu   = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic [1:0]  alu_op;
      logic [1:0]  a_src;
      logic        alu_src;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        reg_write;
      logic        branch;
      logic        jump;
   } idex_t;

   logic [31:0] rf_q [RF_DEPTH];
   logic [31:0] rf_d [RF_DEPTH];
   idex_t       idex_q, idex_d, dec;

   logic [6:0]  opcode;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] rdata1, rdata2;
   logic        wb_wr_en;
   logic        hz;

   assign opcode   = instruction_in[6:0];
   assign rs1      = instruction_in[19:15];
   assign rs2      = instruction_in[24:20];
   assign rd       = instruction_in[11:7];
   assign wb_wr_en = RegWrite_wb && (rd_wb != 5'd0);

   // Register file next state; entry 0 is never written so x0 stays zero.
   always_comb begin
      rf_d = rf_q;
      if (reset) begin
         for (int i = 0; i < RF_DEPTH; i++) rf_d[i] = '0;
      end else if (wb_wr_en) begin
         rf_d[rd_wb] = wdata_wb;
      end
   end

   always_comb begin
      rdata1 = (rs1 == 5'd0) ? '0 : rf_q[rs1];
      rdata2 = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef RF_WB_BYPASS_EN
      if (wb_wr_en && (rd_wb == rs1)) rdata1 = wdata_wb;
      if (wb_wr_en && (rd_wb == rs2)) rdata2 = wdata_wb;
`endif
   end

   // Opcode decode and immediate generation.
   always_comb begin
      dec          = '0;
      dec.pc       = PC_in;
      dec.rdata1   = rdata1;
      dec.rdata2   = rdata2;
      dec.rs1      = rs1;
      dec.rs2      = rs2;
      dec.rd       = rd;
      dec.funct3   = instruction_in[14:12];
      dec.funct7b5 = instruction_in[30];
      unique case (opcode)
         OpR: begin
            dec.reg_write = 1'b1;
            dec.alu_op    = 2'b10;
         end
         OpIAlu: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_op    = 2'b11;
            dec.imm       = {{20{instruction_in[31]}}, instruction_in[31:20]};
         end
         OpLoad: begin
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.imm        = {{20{instruction_in[31]}}, instruction_in[31:20]};
         end
         OpStore: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm       = {{20{instruction_in[31]}}, instruction_in[31:25],
                             instruction_in[11:7]};
         end
         OpBranch: begin
            dec.branch = 1'b1;
            dec.alu_op = 2'b01;
            dec.imm    = {{19{instruction_in[31]}}, instruction_in[31], instruction_in[7],
                          instruction_in[30:25], instruction_in[11:8], 1'b0};
         end
         OpJal: begin
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
            dec.a_src     = 2'b01;
            dec.imm       = {{11{instruction_in[31]}}, instruction_in[31],
                             instruction_in[19:12], instruction_in[20],
                             instruction_in[30:21], 1'b0};
         end
         OpJalr: begin
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm       = {{20{instruction_in[31]}}, instruction_in[31:20]};
         end
         OpLui: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.a_src     = 2'b10;
            dec.imm       = {instruction_in[31:12], 12'b0};
         end
         OpAuipc: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.a_src     = 2'b01;
            dec.imm       = {instruction_in[31:12], 12'b0};
         end
         default: ;
      endcase
   end

   // Load-use hazard: the load now in ID/EX targets a source of this instruction.
   // Source fields are compared raw, whether or not the opcode actually uses them.
   assign hz = idex_q.mem_read && (idex_q.rd != 5'd0) &&
               ((idex_q.rd == rs1) || (idex_q.rd == rs2));
   assign stall_out = hz && !PCSrc;

   always_comb begin
      idex_d = dec;
      if (reset || PCSrc || hz) idex_d = '0;
   end

   always_ff @(posedge clk) begin
      rf_q   <= rf_d;
      idex_q <= idex_d;
   end

   assign PC_out       = idex_q.pc;
   assign rdata1_out   = idex_q.rdata1;
   assign rdata2_out   = idex_q.rdata2;
   assign imm_out      = idex_q.imm;
   assign rs1_out      = idex_q.rs1;
   assign rs2_out      = idex_q.rs2;
   assign rd_out       = idex_q.rd;
   assign funct3_out   = idex_q.funct3;
   assign funct7b5_out = idex_q.funct7b5;
   assign ALUOp_out    = idex_q.alu_op;
   assign ASrc_out     = idex_q.a_src;
   assign ALUSrc_out   = idex_q.alu_src;
   assign MemRead_out  = idex_q.mem_read;
   assign MemWrite_out = idex_q.mem_write;
   assign MemtoReg_out = idex_q.mem_to_reg;
   assign RegWrite_out = idex_q.reg_write;
   assign Branch_out   = idex_q.branch;
   assign Jump_out     = idex_q.jump;

endmodule

// File: tb/tb_instr_decode.sv
// Testbench for instr_decode: directed vector table, hand-written hazard/flush/
// bypass/reset sequences, and random stimulus against a reference model.
module tb_instr_decode;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction_in, PC_in, wdata_wb;
   logic        PCSrc, RegWrite_wb;
   logic [4:0]  rd_wb;
   logic        stall_out;
   logic [31:0] PC_out, rdata1_out, rdata2_out, imm_out;
   logic [4:0]  rs1_out, rs2_out, rd_out;
   logic [2:0]  funct3_out;
   logic        funct7b5_out;
   logic [1:0]  ALUOp_out, ASrc_out;
   logic        ALUSrc_out, MemRead_out, MemWrite_out, MemtoReg_out;
   logic        RegWrite_out, Branch_out, Jump_out;

   always #5 clk = ~clk;

   instr_decode dut (
      .clk            (clk),
      .reset          (reset),
      .instruction_in (instruction_in),
      .PC_in          (PC_in),
      .PCSrc          (PCSrc),
      .RegWrite_wb    (RegWrite_wb),
      .rd_wb          (rd_wb),
      .wdata_wb       (wdata_wb),
      .stall_out      (stall_out),
      .PC_out         (PC_out),
      .rdata1_out     (rdata1_out),
      .rdata2_out     (rdata2_out),
      .imm_out        (imm_out),
      .rs1_out        (rs1_out),
      .rs2_out        (rs2_out),
      .rd_out         (rd_out),
      .funct3_out     (funct3_out),
      .funct7b5_out   (funct7b5_out),
      .ALUOp_out      (ALUOp_out),
      .ASrc_out       (ASrc_out),
      .ALUSrc_out     (ALUSrc_out),
      .MemRead_out    (MemRead_out),
      .MemWrite_out   (MemWrite_out),
      .MemtoReg_out   (MemtoReg_out),
      .RegWrite_out   (RegWrite_out),
      .Branch_out     (Branch_out),
      .Jump_out       (Jump_out)
   );

`ifdef RF_WB_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   // ctrl = {ALUOp[1:0], ASrc[1:0], ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch, Jump}
   logic [10:0] act_ctrl;
   assign act_ctrl = {ALUOp_out, ASrc_out, ALUSrc_out, MemRead_out, MemWrite_out,
                      MemtoReg_out, RegWrite_out, Branch_out, Jump_out};

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        f7b5;
      logic [10:0] ctrl;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [10:0] ctrl;
   } vec_t;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".pc"},     PC_out,              e.pc);
      chk({tag, ".rdata1"}, rdata1_out,          e.rd1);
      chk({tag, ".rdata2"}, rdata2_out,          e.rd2);
      chk({tag, ".imm"},    imm_out,             e.imm);
      chk({tag, ".rs1"},    32'(rs1_out),        32'(e.rs1));
      chk({tag, ".rs2"},    32'(rs2_out),        32'(e.rs2));
      chk({tag, ".rd"},     32'(rd_out),         32'(e.rd));
      chk({tag, ".funct3"}, 32'(funct3_out),     32'(e.f3));
      chk({tag, ".f7b5"},   32'(funct7b5_out),   32'(e.f7b5));
      chk({tag, ".ctrl"},   32'(act_ctrl),       32'(e.ctrl));
   endtask

   // Control vector for each opcode, straight from the decode table.
   function automatic logic [10:0] ctrl_of(input logic [6:0] op);
      case (op)
         7'b0110011: return 11'b10_00_0000100;
         7'b0010011: return 11'b11_00_1000100;
         7'b0000011: return 11'b00_00_1101100;
         7'b0100011: return 11'b00_00_1010000;
         7'b1100011: return 11'b01_00_0000010;
         7'b1101111: return 11'b00_01_0000101;
         7'b1100111: return 11'b00_00_1000101;
         7'b0110111: return 11'b00_10_1000100;
         7'b0010111: return 11'b00_01_1000100;
         default:    return 11'b0;
      endcase
   endfunction

   function automatic logic [31:0] imm_of(input logic [31:0] i);
      case (i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: return 32'($signed(i[31:20]));
         7'b0100011: return 32'($signed({i[31:25], i[11:7]}));
         7'b1100011: return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         7'b0110111, 7'b0010111: return {i[31:12], 12'b0};
         7'b1101111: return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         default: return 32'b0;
      endcase
   endfunction

   function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] pc,
                                         input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      e.pc   = pc;
      e.rd1  = r1;
      e.rd2  = r2;
      e.imm  = imm_of(i);
      e.rs1  = i[19:15];
      e.rs2  = i[24:20];
      e.rd   = i[11:7];
      e.f3   = i[14:12];
      e.f7b5 = i[30];
      e.ctrl = ctrl_of(i[6:0]);
      return e;
   endfunction

   logic [31:0] m_rf [32];
   vec_t        vecs [12];

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      instruction_in = 32'h0;
      PCSrc          = 1'b0;
      RegWrite_wb    = 1'b0;
      rd_wb          = 5'd0;
      wdata_wb       = 32'h0;
   endtask

   // Reads every register through add x0,xi,xi and expects zero.
   task automatic check_regs_zero(input string tag);
      for (int r = 1; r < 32; r++) begin
         instruction_in = (32'(r) << 20) | (32'(r) << 15) | 32'h33;
         step();
         chk({tag, ".rs1_zero"}, rdata1_out, 32'h0);
         chk({tag, ".rs2_zero"}, rdata2_out, 32'h0);
      end
      instruction_in = 32'h0;
      step();
   endtask

   initial begin
      exp_t        zero_e, exp_cur, exp_nxt;
      logic [31:0] r1v, r2v;
      logic [4:0]  s1, s2;
      logic        hz_m;
      logic [6:0]  ops [11];

      zero_e = '0;
      vecs[0]  = '{32'h00500093, 32'h00000005,  5'd1,  11'b11_00_1000100};
      vecs[1]  = '{32'hFE000CE3, 32'hFFFFFFF8,  5'd25, 11'b01_00_0000010};
      vecs[2]  = '{32'h0000A103, 32'h00000000,  5'd2,  11'b00_00_1101100};
      vecs[3]  = '{32'h002101B3, 32'h00000000,  5'd3,  11'b10_00_0000100};
      vecs[4]  = '{32'hFE20AE23, 32'hFFFFFFFC,  5'd28, 11'b00_00_1010000};
      vecs[5]  = '{32'hFFDFF0EF, 32'hFFFFFFFC,  5'd1,  11'b00_01_0000101};
      vecs[6]  = '{32'h0010006F, 32'h00000800,  5'd0,  11'b00_01_0000101};
      vecs[7]  = '{32'h00C280E7, 32'h0000000C,  5'd1,  11'b00_00_1000101};
      vecs[8]  = '{32'h123453B7, 32'h12345000,  5'd7,  11'b00_10_1000100};
      vecs[9]  = '{32'hFFFFF417, 32'hFFFFF000,  5'd8,  11'b00_01_1000100};
      vecs[10] = '{32'hFFF00213, 32'hFFFFFFFF,  5'd4,  11'b11_00_1000100};
      vecs[11] = '{32'h0000007F, 32'h00000000,  5'd0,  11'b0};
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00, 7'h7F};

      // Reset with random instructions in flight.
      idle_inputs();
      PC_in = 32'h0;
      reset = 1'b1;
      repeat (2) begin
         instruction_in = $urandom;
         PC_in          = $urandom;
         @(posedge clk);
      end
      @(negedge clk);
      chk_all("reset", zero_e);
      chk("reset.stall", 32'(stall_out), 32'h0);
      reset = 1'b0;
      idle_inputs();
      check_regs_zero("reset");

      // Same-cycle WB write of x5 while add x6,x5,x0 is decoded.
      instruction_in = 32'h00028333;
      RegWrite_wb = 1'b1;
      rd_wb       = 5'd5;
      wdata_wb    = 32'hDEADBEEF;
      step();
      chk("bypass.same_cycle", rdata1_out, Bypass ? 32'hDEADBEEF : 32'h0);
      chk("bypass.rd", 32'(rd_out), 32'd6);
      RegWrite_wb = 1'b0;
      step();
      chk("bypass.next_cycle", rdata1_out, 32'hDEADBEEF);

      // Write to x0 is ignored.
      instruction_in = 32'h00000033;
      RegWrite_wb = 1'b1;
      rd_wb       = 5'd0;
      wdata_wb    = 32'h12345678;
      step();
      RegWrite_wb = 1'b0;
      step();
      chk("x0.rdata1", rdata1_out, 32'h0);
      chk("x0.rdata2", rdata2_out, 32'h0);
      idle_inputs();
      step();

      // Directed decode table; a bubble follows each entry so no hazard can form.
      for (int i = 0; i < 12; i++) begin
         instruction_in = vecs[i].instr;
         PC_in          = 32'h1000 + 32'(i) * 8;
         #1;
         chk($sformatf("vec%0d.stall", i), 32'(stall_out), 32'h0);
         step();
         chk($sformatf("vec%0d.imm", i),  imm_out,        vecs[i].imm);
         chk($sformatf("vec%0d.rd", i),   32'(rd_out),    32'(vecs[i].rd));
         chk($sformatf("vec%0d.ctrl", i), 32'(act_ctrl),  32'(vecs[i].ctrl));
         chk($sformatf("vec%0d.pc", i),   PC_out,         32'h1000 + 32'(i) * 8);
         if (i == 0) chk("addi.rdata1", rdata1_out, 32'h0);
         instruction_in = 32'h0;
         step();
      end

      // Load-use: one bubble, then the dependent add issues.
      instruction_in = 32'h0000A103;
      step();
      instruction_in = 32'h002101B3;
      #1;
      chk("lu.stall", 32'(stall_out), 32'h1);
      step();
      chk("lu.bubble_ctrl", 32'(act_ctrl), 32'h0);
      chk("lu.bubble_rd", 32'(rd_out), 32'h0);
      chk("lu.stall_drop", 32'(stall_out), 32'h0);
      step();
      chk("lu.add_rd", 32'(rd_out), 32'd3);
      chk("lu.add_aluop", 32'(ALUOp_out), 32'h2);
      chk("lu.add_regwrite", 32'(RegWrite_out), 32'h1);
      instruction_in = 32'h0;
      step();

      // Flush during a load-use hazard.
      instruction_in = 32'h0000A103;
      step();
      instruction_in = 32'h002101B3;
      PCSrc = 1'b1;
      #1;
      chk("flush.stall", 32'(stall_out), 32'h0);
      step();
      chk("flush.ctrl", 32'(act_ctrl), 32'h0);
      chk("flush.rd", 32'(rd_out), 32'h0);
      idle_inputs();
      step();

      // Random phase against the reference model, from a clean reset.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
      exp_cur = '0;
      for (int n = 0; n < 2000; n++) begin
         chk_all("rnd", exp_cur);
         instruction_in = $urandom;
         instruction_in[6:0]   = ops[$urandom_range(10, 0)];
         if (instruction_in[6:0] == 7'h7F) instruction_in[6:0] = 7'($urandom);
         instruction_in[19:15] = 5'($urandom_range(7, 0));
         instruction_in[24:20] = 5'($urandom_range(7, 0));
         instruction_in[11:7]  = 5'($urandom_range(7, 0));
         PC_in       = $urandom;
         PCSrc       = ($urandom_range(7, 0) == 0);
         RegWrite_wb = $urandom_range(1, 0) != 0;
         rd_wb       = 5'($urandom_range(7, 0));
         wdata_wb    = $urandom;
         #1;
         s1 = instruction_in[19:15];
         s2 = instruction_in[24:20];
         hz_m = exp_cur.ctrl[5] && (exp_cur.rd != 0) && (exp_cur.rd == s1 || exp_cur.rd == s2);
         chk("rnd.stall", 32'(stall_out), 32'(hz_m && !PCSrc));
         r1v = (s1 == 0) ? 32'h0 : m_rf[s1];
         r2v = (s2 == 0) ? 32'h0 : m_rf[s2];
         if (Bypass && RegWrite_wb && rd_wb != 0 && rd_wb == s1) r1v = wdata_wb;
         if (Bypass && RegWrite_wb && rd_wb != 0 && rd_wb == s2) r2v = wdata_wb;
         exp_nxt = (PCSrc || hz_m) ? '0 : model_decode(instruction_in, PC_in, r1v, r2v);
         @(posedge clk);
         if (RegWrite_wb && rd_wb != 0) m_rf[rd_wb] = wdata_wb;
         exp_cur = exp_nxt;
         @(negedge clk);
      end

      // Fill the register file, then reset in the middle of a load-use stall.
      idle_inputs();
      for (int r = 1; r < 32; r++) begin
         RegWrite_wb = 1'b1;
         rd_wb       = 5'(r);
         wdata_wb    = 32'hA500_0000 | 32'(r);
         step();
      end
      RegWrite_wb = 1'b0;
      instruction_in = 32'h0000A103;
      step();
      instruction_in = 32'h002101B3;
      #1;
      chk("mid.stall", 32'(stall_out), 32'h1);
      reset = 1'b1;
      step();
      chk_all("mid_reset", zero_e);
      chk("mid_reset.stall", 32'(stall_out), 32'h0);
      step();
      reset = 1'b0;
      instruction_in = 32'h0;
      step();
      check_regs_zero("mid_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
